// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//   IF-stage sequencer. Owns the program counter and drives the instruction
//   memory reset, the IF/ID load enable and clear, and the ID/EX clear. It
//   handles boot, load-use stalls, taken-branch redirects resolved in EX, and
//   halt/resume.
//
// Optional build macro:
//   FETCH_PERF_CNT_EN  adds saturating stall_cnt_o / flush_cnt_o counters.
//
// Ports:
//   CLK                 in   1  clock, rising edge
//   RST                 in   1  synchronous active-high reset
//   start_i             in   1  IDLE -> BOOT, HALT -> RUN
//   stall_req_i         in   1  load-use hazard: hold PC and IF/ID
//   halt_i              in   1  halt instruction decoded in ID
//   branch_taken_ex_i   in   1  branch resolved taken in EX
//   branch_target_ex_i  in   N  redirect address
//   pc_o                out  N  fetch address
//   fetch_valid_o       out  1  memory output valid this cycle
//   mem_rst_o           out  1  instruction memory reset
//   pipe_if_id_en_o     out  1  IF/ID load enable
//   pipe_if_id_clr_o    out  1  IF/ID clear (NOP)
//   pipe_id_ex_clr_o    out  1  ID/EX clear (bubble)
//   state_o             out  3  current state (debug)
//   stall_cnt_o         out 32  RUN stall cycles       (FETCH_PERF_CNT_EN)
//   flush_cnt_o         out 32  IF/ID clear cycles     (FETCH_PERF_CNT_EN)
// -----------------------------------------------------------------------------
module fetch_sequencer #(
  parameter int             N           = 32,
  parameter logic [N-1:0]   RESET_PC    = '0,
  parameter int             BOOT_CYCLES = 2,
  parameter int             FLUSH_DEPTH = 2
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         start_i,
  input  logic         stall_req_i,
  input  logic         halt_i,
  input  logic         branch_taken_ex_i,
  input  logic [N-1:0] branch_target_ex_i,
  output logic [N-1:0] pc_o,
  output logic         fetch_valid_o,
  output logic         mem_rst_o,
  output logic         pipe_if_id_en_o,
  output logic         pipe_if_id_clr_o,
  output logic         pipe_id_ex_clr_o,
  output logic [2:0]   state_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]  stall_cnt_o,
  output logic [31:0]  flush_cnt_o
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BOOT  = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  // Counter widths hold BOOT_CYCLES-1 and FLUSH_DEPTH-1 respectively.
  localparam int BCW = (BOOT_CYCLES > 2) ? $clog2(BOOT_CYCLES) : 1;
  localparam int FCW = (FLUSH_DEPTH > 2) ? $clog2(FLUSH_DEPTH) : 1;

  state_t         r_state;
  logic [N-1:0]   r_pc;
  logic [BCW-1:0] r_boot_cnt;
  logic [FCW-1:0] r_flush_cnt;   // FLUSH cycles still to run, including current

  state_t         w_state_nxt;
  logic [N-1:0]   w_pc_nxt;
  logic [BCW-1:0] w_boot_nxt;
  logic [FCW-1:0] w_flush_nxt;
  logic [N-1:0]   w_pc_inc;
  logic [N-1:0]   w_target;
  logic           w_redirect;
  logic           w_stall_cyc;

  assign w_pc_inc   = r_pc + N'(4);
  assign w_target   = {branch_target_ex_i[N-1:2], 2'b00};
  // A taken branch wins over halt and stall in both RUN and FLUSH.
  assign w_redirect = branch_taken_ex_i && (r_state == S_RUN || r_state == S_FLUSH);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_boot_nxt       = r_boot_cnt;
    w_flush_nxt      = r_flush_cnt;
    w_stall_cyc      = 1'b0;
    fetch_valid_o    = 1'b0;
    mem_rst_o        = 1'b0;
    pipe_if_id_en_o  = 1'b0;
    pipe_if_id_clr_o = 1'b0;
    pipe_id_ex_clr_o = 1'b0;

    if (w_redirect) begin
      // Kill the wrong-path instructions in IF/ID and ID/EX this cycle; the
      // target reaches pc_o on the next edge.
      pipe_if_id_clr_o = 1'b1;
      pipe_id_ex_clr_o = 1'b1;
      w_pc_nxt         = w_target;
      if (FLUSH_DEPTH > 1) begin
        w_state_nxt = S_FLUSH;
        w_flush_nxt = FCW'(FLUSH_DEPTH - 1);
      end else begin
        w_state_nxt = S_RUN;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            w_state_nxt = S_BOOT;
            w_pc_nxt    = RESET_PC;
            w_boot_nxt  = '0;
          end
        end
        S_BOOT: begin
          mem_rst_o = 1'b1;
          w_pc_nxt  = RESET_PC;
          if (r_boot_cnt == BCW'(BOOT_CYCLES - 1)) begin
            w_state_nxt = S_RUN;
            w_boot_nxt  = '0;
          end else begin
            w_boot_nxt = r_boot_cnt + BCW'(1);
          end
        end
        S_RUN: begin
          if (halt_i) begin
            pipe_if_id_clr_o = 1'b1;
            w_state_nxt      = S_HALT;
          end else if (stall_req_i) begin
            // Hold PC and IF/ID; bubble into EX.
            fetch_valid_o    = 1'b1;
            pipe_id_ex_clr_o = 1'b1;
            w_stall_cyc      = 1'b1;
          end else begin
            fetch_valid_o   = 1'b1;
            pipe_if_id_en_o = 1'b1;
            w_pc_nxt        = w_pc_inc;
          end
        end
        S_FLUSH: begin
          // stall_req_i is meaningless while IF/ID is being cleared.
          pipe_if_id_clr_o = 1'b1;
          w_pc_nxt         = w_pc_inc;
          if (r_flush_cnt <= FCW'(1)) begin
            w_state_nxt = S_RUN;
            w_flush_nxt = '0;
          end else begin
            w_flush_nxt = r_flush_cnt - FCW'(1);
          end
        end
        S_HALT: begin
          if (start_i) w_state_nxt = S_RUN;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (RST) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_boot_cnt  <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_boot_cnt  <= w_boot_nxt;
      r_flush_cnt <= w_flush_nxt;
    end
  end

  assign pc_o    = r_pc;
  assign state_o = r_state;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cyc_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_stall_cnt     <= '0;
      r_flush_cyc_cnt <= '0;
    end else begin
      if (w_stall_cyc && r_stall_cnt != 32'hFFFF_FFFF)
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (pipe_if_id_clr_o && r_flush_cyc_cnt != 32'hFFFF_FFFF)
        r_flush_cyc_cnt <= r_flush_cyc_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cyc_cnt;
`else
  // w_stall_cyc only feeds the optional counters.
  logic w_unused;
  assign w_unused = w_stall_cyc;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//   Table-driven bench for fetch_sequencer. Each record gives the inputs for
//   one cycle and the outputs expected during that cycle. A hand-written boot
//   sequence follows the table.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, stall_req_i, halt_i, branch_taken_ex_i;
  logic [31:0] branch_target_ex_i;
  logic [31:0] pc_o;
  logic        fetch_valid_o, mem_rst_o, pipe_if_id_en_o;
  logic        pipe_if_id_clr_o, pipe_id_ex_clr_o;
  logic [2:0]  state_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_o, flush_cnt_o;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .CLK                (clk),
    .RST                (rst),
    .start_i            (start_i),
    .stall_req_i        (stall_req_i),
    .halt_i             (halt_i),
    .branch_taken_ex_i  (branch_taken_ex_i),
    .branch_target_ex_i (branch_target_ex_i),
    .pc_o               (pc_o),
    .fetch_valid_o      (fetch_valid_o),
    .mem_rst_o          (mem_rst_o),
    .pipe_if_id_en_o    (pipe_if_id_en_o),
    .pipe_if_id_clr_o   (pipe_if_id_clr_o),
    .pipe_id_ex_clr_o   (pipe_id_ex_clr_o),
    .state_o            (state_o)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cnt_o        (stall_cnt_o),
    .flush_cnt_o        (flush_cnt_o)
`endif
  );

  // in  = {rst, start, stall, halt, branch}
  // out = {fetch_valid, mem_rst, if_id_en, if_id_clr, id_ex_clr}
  typedef struct {
    logic [4:0]  in;
    logic [31:0] tgt;
    logic [31:0] pc;
    logic [4:0]  out;
    logic [2:0]  st;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [4:0] in, input logic [31:0] tgt,
                              input logic [31:0] pc, input logic [4:0] out,
                              input logic [2:0] st);
    vec_t v;
    v.in = in; v.tgt = tgt; v.pc = pc; v.out = out; v.st = st;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic drive(input logic [4:0] in, input logic [31:0] tgt);
    {rst, start_i, stall_req_i, halt_i, branch_taken_ex_i} = in;
    branch_target_ex_i = tgt;
  endtask

  initial begin
    logic [39:0] act, exp;
    int          mr_cycles;
    int          n_run;
    logic [31:0] run_pc [4];

    // Row-by-row scenario: boot, run, stall, redirects, halt/resume, wrap,
    // reset in FLUSH, ignored inputs in IDLE, reset in BOOT.
    vecs.push_back(mk(5'b00000, 32'h0,        32'h0,        5'b00000, 3'd0)); // 0 reset state
    vecs.push_back(mk(5'b01000, 32'h0,        32'h0,        5'b00000, 3'd0)); // 1 start
    vecs.push_back(mk(5'b00000, 32'h0,        32'h0,        5'b01000, 3'd1)); // 2 boot
    vecs.push_back(mk(5'b00000, 32'h0,        32'h0,        5'b01000, 3'd1)); // 3 boot
    vecs.push_back(mk(5'b00000, 32'h0,        32'h0,        5'b10100, 3'd2)); // 4
    vecs.push_back(mk(5'b00000, 32'h0,        32'h4,        5'b10100, 3'd2)); // 5
    vecs.push_back(mk(5'b00000, 32'h0,        32'h8,        5'b10100, 3'd2)); // 6
    vecs.push_back(mk(5'b00100, 32'h0,        32'hC,        5'b10001, 3'd2)); // 7 stall
    vecs.push_back(mk(5'b00100, 32'h0,        32'hC,        5'b10001, 3'd2)); // 8 stall
    vecs.push_back(mk(5'b00100, 32'h0,        32'hC,        5'b10001, 3'd2)); // 9 stall
    vecs.push_back(mk(5'b00000, 32'h0,        32'hC,        5'b10100, 3'd2)); // 10
    vecs.push_back(mk(5'b00000, 32'h0,        32'h10,       5'b10100, 3'd2)); // 11
    vecs.push_back(mk(5'b00001, 32'h43,       32'h14,       5'b00011, 3'd2)); // 12 branch, misaligned
    vecs.push_back(mk(5'b00100, 32'h0,        32'h40,       5'b00010, 3'd3)); // 13 flush, stall ignored
    vecs.push_back(mk(5'b00101, 32'h80,       32'h44,       5'b00011, 3'd2)); // 14 branch+stall
    vecs.push_back(mk(5'b00001, 32'h100,      32'h80,       5'b00011, 3'd3)); // 15 branch in flush
    vecs.push_back(mk(5'b00000, 32'h0,        32'h100,      5'b00010, 3'd3)); // 16 restarted flush
    vecs.push_back(mk(5'b00011, 32'h10,       32'h104,      5'b00011, 3'd2)); // 17 branch+halt
    vecs.push_back(mk(5'b00000, 32'h0,        32'h10,       5'b00010, 3'd3)); // 18
    vecs.push_back(mk(5'b00010, 32'h0,        32'h14,       5'b00010, 3'd2)); // 19 halt
    vecs.push_back(mk(5'b00000, 32'h0,        32'h14,       5'b00000, 3'd4)); // 20
    vecs.push_back(mk(5'b00000, 32'h0,        32'h14,       5'b00000, 3'd4)); // 21
    vecs.push_back(mk(5'b00000, 32'h0,        32'h14,       5'b00000, 3'd4)); // 22
    vecs.push_back(mk(5'b00000, 32'h0,        32'h14,       5'b00000, 3'd4)); // 23
    vecs.push_back(mk(5'b01000, 32'h0,        32'h14,       5'b00000, 3'd4)); // 24 resume
    vecs.push_back(mk(5'b00000, 32'h0,        32'h14,       5'b10100, 3'd2)); // 25
    vecs.push_back(mk(5'b00000, 32'h0,        32'h18,       5'b10100, 3'd2)); // 26
    vecs.push_back(mk(5'b00001, 32'hFFFF_FFFC, 32'h1C,      5'b00011, 3'd2)); // 27 branch to top
    vecs.push_back(mk(5'b00000, 32'h0,        32'hFFFF_FFFC, 5'b00010, 3'd3)); // 28
    vecs.push_back(mk(5'b00000, 32'h0,        32'h0,        5'b10100, 3'd2)); // 29 wrapped
    vecs.push_back(mk(5'b00001, 32'h200,      32'h4,        5'b00011, 3'd2)); // 30 branch
    vecs.push_back(mk(5'b10000, 32'h0,        32'h200,      5'b00010, 3'd3)); // 31 reset in flush
    vecs.push_back(mk(5'b00111, 32'h300,      32'h0,        5'b00000, 3'd0)); // 32 ignored in IDLE
    vecs.push_back(mk(5'b00000, 32'h0,        32'h0,        5'b00000, 3'd0)); // 33
    vecs.push_back(mk(5'b01000, 32'h0,        32'h0,        5'b00000, 3'd0)); // 34 start
    vecs.push_back(mk(5'b10000, 32'h0,        32'h0,        5'b01000, 3'd1)); // 35 reset in boot
    vecs.push_back(mk(5'b00000, 32'h0,        32'h0,        5'b00000, 3'd0)); // 36

    drive(5'b10000, 32'h0);
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].in, vecs[i].tgt);
      #1;
      act = {pc_o, fetch_valid_o, mem_rst_o, pipe_if_id_en_o,
             pipe_if_id_clr_o, pipe_id_ex_clr_o, state_o};
      exp = {vecs[i].pc, vecs[i].out, vecs[i].st};
      check($sformatf("row%0d {pc,fv,mr,en,clr1,clr2,st}", i), 64'(act), 64'(exp));
`ifdef FETCH_PERF_CNT_EN
      if (i == 14) begin
        check("stall_cnt after 3 stalls", 64'(stall_cnt_o), 64'd3);
        check("flush_cnt after 1 redirect", 64'(flush_cnt_o), 64'd2);
      end
      if (i == 33) begin
        check("stall_cnt after reset", 64'(stall_cnt_o), 64'd0);
        check("flush_cnt after reset", 64'(flush_cnt_o), 64'd0);
      end
`endif
    end

    // Boot sequence: one-cycle start pulse, count mem_rst_o cycles and collect
    // the first four RUN fetch addresses within a bounded window.
    @(negedge clk);
    drive(5'b01000, 32'h0);
    @(negedge clk);
    drive(5'b00000, 32'h0);
    mr_cycles = 0;
    n_run     = 0;
    for (int c = 0; c < 12 && n_run < 4; c++) begin
      #1;
      if (mem_rst_o) mr_cycles++;
      if (state_o == 3'd2) begin
        run_pc[n_run] = pc_o;
        n_run++;
      end
      @(negedge clk);
    end
    check("boot mem_rst cycles", 64'(mr_cycles), 64'd2);
    check("boot run cycles seen", 64'(n_run), 64'd4);
    for (int k = 0; k < 4; k++)
      check($sformatf("boot pc[%0d]", k), 64'(n_run > k ? run_pc[k] : 32'hDEAD_BEEF),
            64'(32'(4 * k)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
